// File: rtl/update_cycle_scheduler.sv
// Schedules backend update cycles: trigger, wait for completion (bounded by a timeout),
// optional holdoff, repeating until the target count is reached, aborted or timed out.
module update_cycle_scheduler #(
  parameter int PERIOD_WIDTH   = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    period_load,
  input  logic [PERIOD_WIDTH-1:0] period_value,
  input  logic [COUNT_WIDTH-1:0]  cycle_target,
  input  logic                    update_cycle_complete,
  output logic                    control_trigger,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [COUNT_WIDTH-1:0]  cycles_done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRIGGER = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]              state_reg, state_next;
  logic [PERIOD_WIDTH-1:0] period_reg, period_next;
  logic [PERIOD_WIDTH-1:0] holdoff_reg, holdoff_next;
  logic [COUNT_WIDTH-1:0]  target_reg, target_next;
  logic [COUNT_WIDTH-1:0]  cycles_next, cycles_inc;
  logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;
  logic                    done_next, error_next;

  assign cycles_inc = (&cycles_done) ? cycles_done : cycles_done + 1'b1;

  always_comb begin
    state_next   = state_reg;
    period_next  = period_load ? period_value : period_reg;
    holdoff_next = holdoff_reg;
    target_next  = target_reg;
    cycles_next  = cycles_done;
    timer_next   = timer_reg;
    done_next    = 1'b0;
    error_next   = timeout_err;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next  = TRIGGER;
          cycles_next = '0;
          error_next  = 1'b0;
          target_next = cycle_target;
          timer_next  = '0;
        end
      end
      TRIGGER: begin
        state_next = WAIT;
        timer_next = '0;
      end
      WAIT: begin
        timer_next = timer_reg + 1'b1;
        // Completion outranks a timeout landing on the same cycle.
        if (update_cycle_complete) begin
          cycles_next = cycles_inc;
          if (target_reg != '0 && cycles_inc == target_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (period_reg == '0) begin
            state_next = TRIGGER;
          end else begin
            state_next   = HOLDOFF;
            holdoff_next = period_reg - 1'b1;
          end
        end else if (timer_reg == TIMER_LAST) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      default: begin
        if (holdoff_reg == '0) state_next = TRIGGER;
        else holdoff_next = holdoff_reg - 1'b1;
      end
    endcase

    // Abort overrides every other event and leaves the count untouched.
    if (abort && state_reg != IDLE) begin
      state_next  = IDLE;
      cycles_next = cycles_done;
      done_next   = 1'b0;
      error_next  = timeout_err;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      period_reg      <= '0;
      holdoff_reg     <= '0;
      target_reg      <= '0;
      timer_reg       <= '0;
      cycles_done     <= '0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
      control_trigger <= 1'b0;
    end else begin
      state_reg       <= state_next;
      period_reg      <= period_next;
      holdoff_reg     <= holdoff_next;
      target_reg      <= target_next;
      timer_reg       <= timer_next;
      cycles_done     <= cycles_next;
      done            <= done_next;
      timeout_err     <= error_next;
      busy            <= (state_next != IDLE);
      control_trigger <= (state_next == TRIGGER);
    end
  end

endmodule

// File: tb/tb_update_cycle_scheduler.sv
// Randomized and directed bench for update_cycle_scheduler with a timeline-arithmetic reference model.
module tb_update_cycle_scheduler;

  localparam int PW   = 8;
  localparam int CW   = 4;
  localparam int TMO  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock, reset_n, start, abort, period_load, update_cycle_complete;
  logic [PW-1:0] period_value;
  logic [CW-1:0] cycle_target;
  logic          control_trigger, busy, done, timeout_err;
  logic [CW-1:0] cycles_done;

  update_cycle_scheduler #(
    .PERIOD_WIDTH(PW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .period_load(period_load), .period_value(period_value), .cycle_target(cycle_target),
    .update_cycle_complete(update_cycle_complete), .control_trigger(control_trigger),
    .busy(busy), .done(done), .timeout_err(timeout_err), .cycles_done(cycles_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_pass, n_total, cyc;
  int delay_q[$], gap_q[$], trig_q[$], done_q[$], exp_trig_q[$];
  int run_s, end_cyc, obs_cycles, obs_err, obs_done;
  int exp_done, exp_end, exp_cycles, exp_err;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic load_period(input int v);
    period_load  = 1'b1;
    period_value = PW'(v);
    step();
    period_load  = 1'b0;
  endtask

  // Starts a sequence and plays the backend: completion delay_q[i] clocks after trigger i.
  task automatic run_seq(input int ab_rel, input int ld_rel, input int ld_val, input int tgt, input bit spur);
    int comp_at, idx;
    trig_q.delete();
    done_q.delete();
    end_cyc = -1;
    comp_at = -1;
    idx = 0;
    run_s = cyc;
    start = 1'b1;
    cycle_target = CW'(tgt);
    for (int k = 0; k < 600; k++) begin
      step();
      start = 1'b0; abort = 1'b0; period_load = 1'b0; update_cycle_complete = 1'b0;
      if (control_trigger) begin
        trig_q.push_back(cyc);
        comp_at = -1;
        if (idx < delay_q.size()) comp_at = cyc + delay_q[idx];
        idx++;
      end
      if (done) done_q.push_back(cyc);
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      if (cyc == comp_at) update_cycle_complete = 1'b1;
      if (ab_rel > 0 && cyc == run_s + ab_rel) abort = 1'b1;
      if (ld_rel > 0 && cyc == run_s + ld_rel) begin
        period_load = 1'b1;
        period_value = PW'(ld_val);
      end
      if (spur && cyc == run_s + 2) begin
        start = 1'b1;
        cycle_target = CW'(tgt + 1);
      end
    end
    obs_cycles = int'(cycles_done);
    obs_err    = int'(timeout_err);
    obs_done   = (done_q.size() == 0) ? -1 : ((done_q.size() == 1) ? done_q[0] : -2);
  endtask

  // Expected timeline computed from trigger/completion arithmetic.
  task automatic model(input int s, input int ab, input int tgt, input int base_p);
    int t, c, d, cnt, i;
    exp_trig_q.delete();
    exp_done = -1; exp_end = -1; exp_err = 0;
    cnt = 0; i = 0; t = s + 1;
    while (1) begin
      if (ab >= 0 && t >= ab + 1) begin exp_end = ab + 1; break; end
      exp_trig_q.push_back(t);
      d = 1000;
      if (i < delay_q.size()) d = delay_q[i];
      if (d > TMO) begin
        if (ab >= 0 && ab <= t + TMO) exp_end = ab + 1;
        else begin exp_end = t + TMO + 1; exp_err = 1; end
        break;
      end
      c = t + d;
      if (ab >= 0 && ab <= c) begin exp_end = ab + 1; break; end
      if (cnt < CMAX) cnt++;
      if (tgt != 0 && cnt == tgt) begin exp_done = c + 1; exp_end = c + 1; break; end
      t = c + ((i < gap_q.size()) ? gap_q[i] : base_p) + 1;
      i++;
    end
    exp_cycles = cnt;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; period_load = 1'b0;
    period_value = '0; cycle_target = '0; update_cycle_complete = 1'b0;
    step(); step();
    n_total++;
    if ({control_trigger, busy, done, timeout_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {control_trigger, busy, done, timeout_err});
    else n_pass++;
    n_total++;
    if (cycles_done !== '0) $display("FAIL reset_cycles: got %0d want 0", cycles_done);
    else n_pass++;
    reset_n = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_bounded();
    int gap;
    load_period(3);
    delay_q = '{5, 5};
    gap_q.delete();
    run_seq(0, 0, 0, 2, 1'b0);
    model(run_s, -1, 2, 3);
    gap = (trig_q.size() >= 2) ? trig_q[1] - trig_q[0] : -1;
    n_total++;
    if (trig_q.size() != 2) $display("FAIL bounded_trig_count: got %0d want 2", trig_q.size());
    else n_pass++;
    n_total++;
    if (gap != 9) $display("FAIL bounded_trig_gap: got %0d want 9", gap);
    else n_pass++;
    n_total++;
    if (obs_done != exp_done) $display("FAIL bounded_done: got cycle %0d want %0d", obs_done, exp_done);
    else n_pass++;
    n_total++;
    if (end_cyc != exp_end || end_cyc != obs_done) $display("FAIL bounded_busy_fall: got %0d want %0d", end_cyc, exp_end);
    else n_pass++;
    n_total++;
    if (obs_cycles != 2) $display("FAIL bounded_cycles: got %0d want 2", obs_cycles);
    else n_pass++;
    step();
  endtask

  task automatic test_zero_period();
    bit bad;
    load_period(0);
    delay_q.delete();
    for (int j = 0; j < 10; j++) delay_q.push_back(1);
    run_seq(21, 0, 0, 0, 1'b0);
    bad = (trig_q.size() != 11);
    for (int j = 1; j < trig_q.size(); j++) if (trig_q[j] - trig_q[j-1] != 2) bad = 1;
    n_total++;
    if (bad) $display("FAIL zero_trig_spacing: got %0d triggers want 11 each 2 apart", trig_q.size());
    else n_pass++;
    n_total++;
    if (end_cyc != run_s + 22 || obs_done != -1) $display("FAIL zero_abort: end got %0d want %0d, done got %0d want -1", end_cyc, run_s + 22, obs_done);
    else n_pass++;
    n_total++;
    if (obs_cycles != 10) $display("FAIL zero_cycles: got %0d want 10", obs_cycles);
    else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    load_period(0);
    delay_q.delete();
    run_seq(0, 0, 0, 1, 1'b0);
    n_total++;
    if (end_cyc != run_s + 1 + TMO + 1 || obs_err != 1 || obs_done != -1) $display("FAIL timeout_end: end got %0d want %0d, err got %0d want 1, done got %0d", end_cyc, run_s + TMO + 2, obs_err, obs_done);
    else n_pass++;
    step(); step();
    n_total++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err);
    else n_pass++;
    delay_q = '{TMO};
    run_seq(0, 0, 0, 1, 1'b0);
    n_total++;
    if (obs_err != 0 || obs_done != run_s + 1 + TMO + 1 || obs_cycles != 1) $display("FAIL timeout_coincide: err got %0d want 0, done got %0d want %0d, cycles got %0d want 1", obs_err, obs_done, run_s + TMO + 2, obs_cycles);
    else n_pass++;
    step();
  endtask

  task automatic test_abort_completion();
    load_period(0);
    delay_q = '{4};
    run_seq(5, 0, 0, 0, 1'b0);
    n_total++;
    if (end_cyc != run_s + 6 || obs_cycles != 0 || obs_done != -1) $display("FAIL abort_vs_complete: end got %0d want %0d, cycles got %0d want 0, done got %0d", end_cyc, run_s + 6, obs_cycles, obs_done);
    else n_pass++;
    step();
  endtask

  task automatic test_saturation();
    load_period(0);
    delay_q.delete();
    for (int j = 0; j < 17; j++) delay_q.push_back(1);
    run_seq(35, 0, 0, 0, 1'b0);
    n_total++;
    if (end_cyc != run_s + 36 || obs_cycles != CMAX) $display("FAIL saturation: cycles got %0d want %0d, end got %0d want %0d", obs_cycles, CMAX, end_cyc, run_s + 36);
    else n_pass++;
    step();
  endtask

  task automatic test_period_change();
    int g0, g1;
    load_period(2);
    delay_q = '{3, 3, 3};
    gap_q = '{2, 7};
    run_seq(0, 5, 7, 3, 1'b0);
    model(run_s, -1, 3, 2);
    g0 = (trig_q.size() >= 3) ? trig_q[1] - trig_q[0] : -1;
    g1 = (trig_q.size() >= 3) ? trig_q[2] - trig_q[1] : -1;
    n_total++;
    if (g0 != 6 || g1 != 11) $display("FAIL period_change_gaps: got %0d,%0d want 6,11", g0, g1);
    else n_pass++;
    n_total++;
    if (obs_done != exp_done || end_cyc != exp_end) $display("FAIL period_change_done: done got %0d want %0d, end got %0d want %0d", obs_done, exp_done, end_cyc, exp_end);
    else n_pass++;
    gap_q.delete();
    step();
  endtask

  task automatic test_reset_mid();
    int trig_seen, busy_seen;
    load_period(0);
    start = 1'b1;
    cycle_target = CW'(1);
    step();
    start = 1'b0;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({control_trigger, busy, done, timeout_err} !== 4'b0 || cycles_done !== '0) $display("FAIL reset_mid_outputs: got flags %b cycles %0d want 0000 0", {control_trigger, busy, done, timeout_err}, cycles_done);
    else n_pass++;
    #3 reset_n = 1'b1;
    trig_seen = 0; busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      update_cycle_complete = 1'($urandom_range(0, 1));
      if (control_trigger) trig_seen++;
      if (busy || done) busy_seen++;
    end
    update_cycle_complete = 1'b0;
    n_total++;
    if (trig_seen != 0 || busy_seen != 0) $display("FAIL reset_mid_quiet: triggers got %0d busy/done cycles got %0d want 0 0", trig_seen, busy_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int p, tgt, ab;
      bit sp, bad;
      p   = $urandom_range(0, 5);
      tgt = $urandom_range(1, 4);
      delay_q.delete();
      gap_q.delete();
      for (int j = 0; j < tgt; j++) delay_q.push_back($urandom_range(1, 10));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 30) : 0;
      sp = 1'($urandom_range(0, 1));
      load_period(p);
      run_seq(ab, 0, 0, tgt, sp);
      model(run_s, (ab > 0) ? run_s + ab : -1, tgt, p);
      bad = (trig_q.size() != exp_trig_q.size());
      if (!bad) foreach (trig_q[j]) if (trig_q[j] != exp_trig_q[j]) bad = 1;
      n_total++;
      if (bad) $display("FAIL rand%0d_triggers: got %0d triggers want %0d (or times differ)", it, trig_q.size(), exp_trig_q.size());
      else n_pass++;
      n_total++;
      if (obs_done != exp_done || end_cyc != exp_end) $display("FAIL rand%0d_end: done got %0d want %0d, end got %0d want %0d", it, obs_done, exp_done, end_cyc, exp_end);
      else n_pass++;
      n_total++;
      if (obs_cycles != exp_cycles || obs_err != exp_err) $display("FAIL rand%0d_status: cycles got %0d want %0d, err got %0d want %0d", it, obs_cycles, exp_cycles, obs_err, exp_err);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    test_reset();
    test_bounded();
    test_zero_period();
    test_timeout();
    test_abort_completion();
    test_saturation();
    test_period_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
